// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: instruction memory, 64-bit PC, valid/ready output register
module instruction_fetch #(
   parameter int          DEPTH    = 64,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data,
   input  logic                     start,
   input  logic                     redirect,
   input  logic [63:0]              redirect_pc,
   input  logic                     ready,
   output logic                     valid,
   output logic [31:0]              instruction,
   output logic [63:0]              instr_pc,
   output logic                     error
);

   localparam int          AW    = $clog2(DEPTH);
   localparam logic [63:0] LIMIT = 64'(DEPTH) << 2;

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   logic [31:0] mem [DEPTH];
   state_t      state, state_n;
   logic [63:0] pc, pc_n, instr_pc_n;
   logic [31:0] instruction_n, rd_word;
   logic        valid_n, error_n;

   // Memory is deliberately left out of reset so programs survive a reset pulse.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
   end

   assign rd_word = mem[pc[AW+1:2]];

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      valid_n       = valid;
      instruction_n = instruction;
      instr_pc_n    = instr_pc;
      error_n       = error;
      if (redirect && state != IDLE) begin
         pc_n    = redirect_pc;
         valid_n = 1'b0;
         if (redirect_pc[1:0] != 2'b00 || redirect_pc >= LIMIT) begin
            state_n = HALT;
            error_n = 1'b1;
         end else begin
            state_n = RUN;
            error_n = 1'b0;
         end
      end else begin
         case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
               // A slot opens when the register is empty or its content is being taken.
               if (!valid || ready) begin
                  if (pc >= LIMIT) begin
                     state_n = HALT;
                     error_n = 1'b1;
                     valid_n = 1'b0;
                  end else begin
                     instruction_n = rd_word;
                     instr_pc_n    = pc;
                     valid_n       = 1'b1;
                     pc_n          = pc + 64'd4;
                  end
               end
            end
            HALT:    valid_n = 1'b0;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         valid       <= 1'b0;
         instruction <= 32'h0;
         instr_pc    <= 64'h0;
         error       <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         valid       <= valid_n;
         instruction <= instruction_n;
         instr_pc    <= instr_pc_n;
         error       <= error_n;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized bench for instruction_fetch against a cycle reference model
module tb_instruction_fetch;

   localparam int          D   = 64;
   localparam logic [63:0] LIM = 64'd256;

   logic        clk = 1'b0, reset = 1'b0, load_en = 1'b0, start = 1'b0, redirect = 1'b0, ready = 1'b0;
   logic [5:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic [63:0] redirect_pc = '0;
   logic        valid, error, v4, e4;
   logic [31:0] instruction, i4;
   logic [63:0] instr_pc, p4;

   int checks = 0, errors = 0;

   // reference model state: mode 0 = idle, 1 = running, 2 = halted
   logic [31:0] mm [D];
   int          ms;
   logic [63:0] mpc, mipc;
   logic [31:0] minstr;
   logic        mvalid, merr;
   logic [31:0] w [4];

   instruction_fetch #(.DEPTH(64), .RESET_PC(64'h0)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(start), .redirect(redirect), .redirect_pc(redirect_pc), .ready(ready),
      .valid(valid), .instruction(instruction), .instr_pc(instr_pc), .error(error));

   instruction_fetch #(.DEPTH(4), .RESET_PC(64'h0)) dut4 (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr[1:0]), .load_data(load_data),
      .start(start), .redirect(redirect), .redirect_pc(redirect_pc), .ready(ready),
      .valid(v4), .instruction(i4), .instr_pc(p4), .error(e4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      ms = 0; mpc = 64'h0; mipc = 64'h0; minstr = 32'h0; mvalid = 1'b0; merr = 1'b0;
   endtask

   task automatic model_update();
      if (ms != 0 && redirect) begin
         mpc = redirect_pc;
         mvalid = 1'b0;
         if ((redirect_pc % 4) != 0 || redirect_pc >= LIM) begin ms = 2; merr = 1'b1; end
         else begin ms = 1; merr = 1'b0; end
      end else if (ms == 0) begin
         if (start) ms = 1;
      end else if (ms == 1 && (!mvalid || ready)) begin
         if (mpc >= LIM) begin
            ms = 2; merr = 1'b1; mvalid = 1'b0;
         end else begin
            minstr = mm[int'(mpc / 4)];
            mipc = mpc;
            mvalid = 1'b1;
            mpc = mpc + 4;
         end
      end
      if (load_en) mm[load_addr] = load_data;
   endtask

   task automatic check_all();
      chk("valid", 64'(valid), 64'(mvalid));
      chk("error", 64'(error), 64'(merr));
      chk("instruction", 64'(instruction), 64'(minstr));
      chk("instr_pc", instr_pc, mipc);
   endtask

   task automatic step(input logic st, input logic rd, input logic [63:0] rpc, input logic rdy,
                       input logic le, input logic [5:0] la, input logic [31:0] ld);
      start = st; redirect = rd; redirect_pc = rpc; ready = rdy;
      load_en = le; load_addr = la; load_data = ld;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      w[0] = 32'h123ABCDF; w[1] = 32'h00500093; w[2] = 32'h002081B3; w[3] = 32'hDEADBEEF;
      model_reset();
      #3;
      chk("rst_valid", 64'(valid), 64'h0);
      chk("rst_instr", 64'(instruction), 64'h0);
      chk("rst_pc", instr_pc, 64'h0);
      chk("rst_error", 64'(error), 64'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 4; i < D; i++) step(0, 0, 0, 0, 1, 6'(i), $urandom);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 6'(i), w[i]);

      // sequential fetch
      step(1, 0, 0, 1, 0, 0, 0);
      chk("start_latency", 64'(valid), 64'h0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("seq0", {instr_pc[31:0], instruction}, {32'h0, w[0]});
      step(0, 0, 0, 1, 0, 0, 0);
      chk("seq1", {instr_pc[31:0], instruction}, {32'h4, w[1]});
      step(0, 0, 0, 1, 0, 0, 0);
      chk("seq2", {instr_pc[31:0], instruction}, {32'h8, w[2]});

      // back-pressure
      step(0, 1, 64'h0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 0);
         chk("bp_hold", {instr_pc[31:0], instruction}, {32'h0, w[0]});
      end
      step(0, 0, 0, 1, 0, 0, 0);
      chk("bp_next", {instr_pc[31:0], instruction}, {32'h4, w[1]});

      // redirect
      step(0, 1, 64'h8, 1, 0, 0, 0);
      chk("redir_bubble", 64'(valid), 64'h0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("redir_target", {instr_pc[31:0], instruction}, {32'h8, w[2]});

      // error then recovery
      step(0, 1, 64'h6, 1, 0, 0, 0);
      chk("err_set", 64'({error, valid}), 64'b10);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("err_halt", 64'({error, valid}), 64'b10);
      step(0, 1, 64'h4, 1, 0, 0, 0);
      chk("err_clear", 64'(error), 64'h0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("recover", {instr_pc[31:0], instruction}, {32'h4, w[1]});

      // asynchronous reset between edges
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", 64'(valid), 64'h0);
      chk("arst_error", 64'(error), 64'h0);
      chk("arst_instr", 64'(instruction), 64'h0);
      chk("arst_dut4_valid", 64'(v4), 64'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      step(0, 0, 0, 1, 0, 0, 0);
      chk("idle_no_fetch", 64'(valid), 64'h0);
      step(1, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("restart", {instr_pc[31:0], instruction}, {32'h0, w[0]});

      // range end on the 4-word instance
      chk("r4_0", {v4, p4[31:0], i4}, {1'b1, 32'h0, w[0]});
      for (int i = 1; i < 4; i++) begin
         step(0, 0, 0, 1, 0, 0, 0);
         chk("r4_word", {v4, p4[31:0], i4}, {1'b1, 32'(i * 4), w[i]});
      end
      step(0, 0, 0, 1, 0, 0, 0);
      chk("r4_halt", 64'({e4, v4}), 64'b10);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("r4_stays", 64'({e4, v4}), 64'b10);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [63:0] rpc;
         case ($urandom_range(0, 3))
            0, 1:    rpc = 64'($urandom_range(0, 63)) * 4;
            2:       rpc = 64'($urandom_range(0, 63)) * 4 + 64'($urandom_range(1, 3));
            default: rpc = LIM + 64'($urandom_range(0, 1000)) * 4;
         endcase
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), rpc,
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
              6'($urandom_range(0, 63)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
